// File: rtl/serial_shift_rx_pkg.sv
// Shared definitions for the serial shift receiver: FSM encoding and stream widths.
package serial_pkg;
  localparam int LED_W = 16;
  localparam int SEG_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } state_t;
endpackage

// File: rtl/serial_shift_rx_if.sv
// MIO-side read port of the serial shift receiver: latched word plus valid/ack handshake.
interface serial_shift_rx_if
  import serial_pkg::*;
#(
  parameter int WIDTH = LED_W,
  parameter int CW    = 7
) ();
  logic             ack;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             overrun;
  logic             len_err;
  logic [CW-1:0]    bit_count;

  modport master (output ack, input data, valid, overrun, len_err, bit_count);
  modport slave  (input ack, output data, valid, overrun, len_err, bit_count);
endinterface

// File: rtl/serial_shift_rx_sync_edge.sv
// 2-FF synchroniser plus history stage; level is the second stage, edges compare it to history.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);
  logic s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= RST_VAL;
      s2 <= RST_VAL;
      s3 <= RST_VAL;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;
endmodule

// File: rtl/serial_shift_rx.sv
// Deserialises one clock/data/latch-enable frame into a parallel word for the MIO bus.
module serial_shift_rx
  import serial_pkg::*;
#(
  parameter int WIDTH = LED_W,
  parameter int CW    = 7
) (
  input  logic              clk,
  input  logic              RSTN,
  input  logic              ser_clk,
  input  logic              ser_do,
  input  logic              ser_pen,
  serial_shift_rx_if.slave  bus
);
  state_t           state, state_nx;
  logic [WIDTH-1:0] sreg;
  logic [CW-1:0]    cnt;
  logic [1:0]       warm;
  logic             clk_lvl, clk_rise, clk_fall;
  logic             do_lvl, do_rise, do_fall;
  logic             pen_lvl, pen_rise, pen_fall;

  logic [WIDTH-1:0] data_q;
  logic             valid_q, overrun_q, len_err_q;
  logic [CW-1:0]    bit_count_q;

  sync_edge #(.RST_VAL(1'b0)) u_sync_clk (
    .clk(clk), .rst_n(RSTN), .din(ser_clk), .level(clk_lvl), .rise(clk_rise), .fall(clk_fall));
  sync_edge #(.RST_VAL(1'b0)) u_sync_do (
    .clk(clk), .rst_n(RSTN), .din(ser_do), .level(do_lvl), .rise(do_rise), .fall(do_fall));
  sync_edge #(.RST_VAL(1'b1)) u_sync_pen (
    .clk(clk), .rst_n(RSTN), .din(ser_pen), .level(pen_lvl), .rise(pen_rise), .fall(pen_fall));

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Synchroniser stages hold reset values, not pin values, for two cycles after
  // release; warm[1] keeps IDLE from trusting the enable level before then.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (warm[1] && pen_lvl) state_nx = ST_ARMED;
      ST_ARMED: if (pen_fall)           state_nx = ST_SHIFT;
      ST_SHIFT: if (pen_rise)           state_nx = ST_LATCH;
      ST_LATCH:                         state_nx = ST_ARMED;
      default:                          state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      warm <= '0;
      sreg <= '0;
      cnt  <= '0;
    end else begin
      warm <= {warm[0], 1'b1};
      if (state == ST_ARMED && pen_fall) begin
        sreg <= '0;
        cnt  <= '0;
      end else if (state == ST_SHIFT && !pen_rise && clk_rise) begin
        sreg <= {sreg[WIDTH-2:0], do_lvl};
        if (cnt != CW'(WIDTH + 1)) cnt <= cnt + 1'b1;
      end
    end
  end

  // A latch coinciding with ack keeps the new frame valid and drops the overrun.
  always_ff @(posedge clk or negedge RSTN) begin
    if (!RSTN) begin
      data_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
      len_err_q   <= 1'b0;
      bit_count_q <= '0;
    end else if (state == ST_LATCH) begin
      data_q      <= sreg;
      bit_count_q <= cnt;
      len_err_q   <= (cnt != CW'(WIDTH));
      valid_q     <= 1'b1;
      overrun_q   <= valid_q & ~bus.ack;
    end else if (bus.ack) begin
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end
  end

  assign bus.data      = data_q;
  assign bus.valid     = valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.len_err   = len_err_q;
  assign bus.bit_count = bit_count_q;
endmodule

// File: tb/tb_serial_shift_rx.sv
// Scoreboard bench for serial_shift_rx: 16-bit and 64-bit instances driven by directed frames.
module tb_serial_shift_rx;
  import serial_pkg::*;

  typedef struct packed {
    logic [63:0] data;
    logic        ovr;
    logic        len;
    logic [6:0]  bc;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sc0 = 1'b0, sd0 = 1'b0, sp0 = 1'b1;
  logic sc1 = 1'b0, sd1 = 1'b0, sp1 = 1'b1;
  int   checks = 0;
  int   errors = 0;
  obs_t q0[$];
  obs_t q1[$];
  obs_t p0, p1;
  logic pv0 = 1'b0, pv1 = 1'b0;

  always #5 clk = ~clk;

  serial_shift_rx_if #(.WIDTH(LED_W), .CW(7)) b0 ();
  serial_shift_rx_if #(.WIDTH(SEG_W), .CW(7)) b1 ();

  serial_shift_rx #(.WIDTH(LED_W), .CW(7)) u_led (
    .clk(clk), .RSTN(rst_n), .ser_clk(sc0), .ser_do(sd0), .ser_pen(sp0), .bus(b0.slave));
  serial_shift_rx #(.WIDTH(SEG_W), .CW(7)) u_seg (
    .clk(clk), .RSTN(rst_n), .ser_clk(sc1), .ser_do(sd1), .ser_pen(sp1), .bus(b1.slave));

  function automatic obs_t mk(input logic [63:0] d, input logic o, input logic l, input int b);
    obs_t r;
    r.data = d; r.ovr = o; r.len = l; r.bc = 7'(b);
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input int sel, input obs_t o);
    obs_t e;
    if ((sel == 0 && q0.size() == 0) || (sel == 1 && q1.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL unexpected_frame%0d actual=%h expected=none", sel, o);
      return;
    end
    if (sel == 0) e = q0.pop_front();
    else          e = q1.pop_front();
    check($sformatf("frame%0d_data", sel), o.data, e.data);
    check($sformatf("frame%0d_overrun", sel), 64'(o.ovr), 64'(e.ovr));
    check($sformatf("frame%0d_len_err", sel), 64'(o.len), 64'(e.len));
    check($sformatf("frame%0d_bit_count", sel), 64'(o.bc), 64'(e.bc));
  endtask

  // Monitors: a new latched frame shows up as valid rising or a change while valid.
  always @(negedge clk) begin
    obs_t o;
    o = mk(64'(b0.data), b0.overrun, b0.len_err, int'(b0.bit_count));
    if (b0.valid && (!pv0 || o != p0)) pop_cmp(0, o);
    pv0 <= b0.valid;
    p0  <= o;
  end

  always @(negedge clk) begin
    obs_t o;
    o = mk(b1.data, b1.overrun, b1.len_err, int'(b1.bit_count));
    if (b1.valid && (!pv1 || o != p1)) pop_cmp(1, o);
    pv1 <= b1.valid;
    p1  <= o;
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic set_pen(input int sel, input logic p);
    if (sel == 0) sp0 = p; else sp1 = p;
  endtask

  task automatic put_bit(input int sel, input logic b);
    if (sel == 0) sd0 = b; else sd1 = b;
    wclk(4);
    if (sel == 0) sc0 = 1'b1; else sc1 = 1'b1;
    wclk(4);
    if (sel == 0) sc0 = 1'b0; else sc1 = 1'b0;
  endtask

  task automatic send_bits(input int sel, input logic [63:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) put_bit(sel, v[i]);
  endtask

  task automatic frame(input int sel, input logic [63:0] v, input int n,
                       input bit ack_latch, input bit chk_lat);
    logic vv;
    set_pen(sel, 1'b0);
    wclk(4);
    send_bits(sel, v, n);
    wclk(4);
    set_pen(sel, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    vv = (sel == 0) ? b0.valid : b1.valid;
    if (chk_lat) check("latency_edge3_valid", 64'(vv), 64'd0);
    if (ack_latch) b0.ack = 1'b1;
    @(posedge clk);
    #1;
    vv = (sel == 0) ? b0.valid : b1.valid;
    if (chk_lat) check("latency_edge4_valid", 64'(vv), 64'd1);
    b0.ack = 1'b0;
    wclk(8);
  endtask

  task automatic do_ack(input logic [15:0] exp_data);
    @(posedge clk);
    #2 b0.ack = 1'b1;
    @(posedge clk);
    #1 b0.ack = 1'b0;
    check("ack_valid", 64'(b0.valid), 64'd0);
    check("ack_overrun", 64'(b0.overrun), 64'd0);
    check("ack_data_hold", 64'(b0.data), 64'(exp_data));
    wclk(2);
  endtask

  initial begin
    b0.ack = 1'b0;
    b1.ack = 1'b0;
    rst_n  = 1'b0;
    wclk(3);
    check("rst_data", 64'(b0.data), 64'd0);
    check("rst_valid", 64'(b0.valid), 64'd0);
    check("rst_overrun", 64'(b0.overrun), 64'd0);
    check("rst_len_err", 64'(b0.len_err), 64'd0);
    check("rst_bit_count", 64'(b0.bit_count), 64'd0);
    check("rst_data64", b1.data, 64'd0);
    rst_n = 1'b1;
    wclk(5);

    q0.push_back(mk(64'hA5C3, 1'b0, 1'b0, 16));
    frame(0, 64'hA5C3, 16, 1'b0, 1'b1);
    do_ack(16'hA5C3);

    q0.push_back(mk(64'h1234, 1'b0, 1'b0, 16));
    frame(0, 64'h1234, 16, 1'b0, 1'b0);
    q0.push_back(mk(64'hBEEF, 1'b1, 1'b0, 16));
    frame(0, 64'hBEEF, 16, 1'b0, 1'b0);
    q0.push_back(mk(64'h5A5A, 1'b0, 1'b0, 16));
    frame(0, 64'h5A5A, 16, 1'b1, 1'b0);
    check("coincident_ack_valid", 64'(b0.valid), 64'd1);
    do_ack(16'h5A5A);

    q0.push_back(mk(64'h0FAB, 1'b0, 1'b1, 12));
    frame(0, 64'hFAB, 12, 1'b0, 1'b0);
    do_ack(16'h0FAB);
    q0.push_back(mk(64'h2345, 1'b0, 1'b1, 17));
    frame(0, 64'h12345, 20, 1'b0, 1'b0);
    do_ack(16'h2345);

    // Reset in the middle of a frame; the tail of that frame must not latch.
    set_pen(0, 1'b0);
    wclk(4);
    send_bits(0, 64'hA5, 8);
    rst_n = 1'b0;
    wclk(3);
    rst_n = 1'b1;
    wclk(2);
    send_bits(0, 64'h5A, 8);
    wclk(4);
    set_pen(0, 1'b1);
    wclk(12);
    check("midrst_no_valid", 64'(b0.valid), 64'd0);
    check("midrst_data_clear", 64'(b0.data), 64'd0);

    q0.push_back(mk(64'h00FF, 1'b0, 1'b0, 16));
    frame(0, 64'h00FF, 16, 1'b0, 1'b0);
    check("post_rst_valid", 64'(b0.valid), 64'd1);

    q1.push_back(mk(64'hDEADBEEF_01234567, 1'b0, 1'b0, 64));
    frame(1, 64'hDEADBEEF_01234567, 64, 1'b0, 1'b1);

    wclk(20);
    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
